uio_bus_arbiter: RTL and testbench
==================================

// Module: uio_bus_arbiter
// PURPOSE
// Shares the 8-bit bidirectional uio pad bus of the tt_um_ user project between N_REQ internal requesters.
// - Arbitration is round-robin.
// - Each requester gets a bounded burst of beats, in one direction (drive or sample).
// - A turnaround gap is inserted whenever the bus direction changes.
// - Sits between the user logic and the uio_in/uio_out/uio_oe pins; it is the only block that drives uio_oe.
// PARAMETERS
// N_REQ       4  number of requesters (2..8)
// MAX_BURST   8  max beats per grant before forced release (1..255)
// TURNAROUND  1  cycles with uio_oe=00 on a direction change (1..3)
// PORTS
// clk      in   1          clock
// rst      in   1          synchronous reset, active-high
// ena      in   1          design-selected; low = bus parked safe
// req      in   N_REQ      per-requester request, level, held until done
// dir      in   N_REQ      per-requester direction: 1=drive pads, 0=sample pads
// last     in   N_REQ      marks final beat of requester's burst
// wdata    in   N_REQ*8    per-requester drive data, slice i = [8i+7:8i]
// gnt      out  N_REQ      one-hot grant; a beat occurs each cycle gnt[i]=1
// rdata    out  8          registered sample of uio_in
// rvalid   out  1          rdata holds a sampled beat
// busy     out  1          state != IDLE
// uio_in   in   8          pad input path
// uio_out  out  8          pad output path
// uio_oe   out  8          pad enable, 8'hFF or 8'h00 only
// BEHAVIOUR
// - Reset (and ena=0): state=IDLE, ptr=0, dir_q=0, beat count=0, gnt=0, uio_oe=00, uio_out=00, rvalid=0, rdata=00, busy=0.
//   The reset vs ena difference is under "ena low" below.
// - Internal registers:
//   - state {IDLE,TURN,GRANT}
//   - w (winner index)
//   - ptr (rr start index)
//   - dir_q (parked bus direction)
//   - tcnt (turnaround counter)
//   - bcnt (beat counter)
// - IDLE: if |req, pick the first set req scanning ptr, ptr+1, ... mod N_REQ, and register w.
//   - dir[w]==dir_q: go to GRANT next cycle.
//   - else: go to TURN with tcnt=TURNAROUND; dir_q<=dir[w] on TURN exit.
// - TURN: uio_oe=00; tcnt decrements; at 0 go to GRANT. req is ignored during TURN.
// - GRANT:
//   - gnt[i] = (i==w) & req[w], combinational.
//   - A beat occurs each cycle gnt[w]=1; bcnt increments per beat.
//   - Release (next state IDLE, ptr<=(w+1) mod N_REQ, bcnt<=0) when any of:
//     - req[w]=0 (no beat that cycle), or
//     - last[w]=1 on a beat, or
//     - bcnt reaches MAX_BURST-1 on a beat.
// - Latency: req seen in IDLE at cycle N gives gnt at N+1 (same direction) or N+1+TURNAROUND (direction change).
//   Minimum one IDLE cycle between consecutive grants.
// - Drive path: uio_oe = (state!=TURN && dir_q) ? FF : 00.
//   uio_out = wdata slice w while gnt[w] & dir_q, else 00 (combinational mux from registered w).
// - Sample path: on an input beat, rdata<=uio_in and rvalid<=1 the next cycle; otherwise rvalid<=0 and rdata holds.
// - dir[w] and wdata changes are ignored for direction once granted; dir is sampled only at arbitration.
// - Simultaneous events:
//   - A req rising in the release cycle is considered in the following IDLE.
//   - The releasing requester has lowest priority next round.
// - ena low, any state: next edge forces IDLE and dir_q=0, ptr held; gnt=0 and uio_oe=00 combinationally while ena=0.
// - rst mid-burst: all registers return to reset values on the next edge; a partial burst is abandoned with no further beats.
// STRUCTURE
// - Package uio_arb_pkg:
//   - state_t enum (IDLE, TURN, GRANT)
//   - OE_DRIVE=8'hFF, OE_SAMPLE=8'h00
//   - counter width function clog2-based
// - Sub-module uio_rr_picker: combinational round-robin priority pick (req, ptr -> idx, any).
// - The FSM, counters and pad muxing stay in this module.
// TESTING
// 1. rst held 2 cycles with req=1111 -> gnt=0000, uio_oe=00, uio_out=00, rvalid=0, busy=0 throughout.
// 2. req0=1, dir0=1, wdata0=A5, last on beat 3 -> 1 TURN cycle (oe=00), then gnt0 for 3 cycles, uio_oe=FF, uio_out=A5; then IDLE with oe=FF parked.
// 3. req=1111, all dir=1, last=0, held -> bursts of 8 beats to 0,1,2,3,0, with a 1-cycle IDLE gap between each.
// 4. req1 drive 2 beats, then req2 sample with uio_in=3C -> TURN cycle with oe=00, then gnt2; rdata=3C, rvalid=1 one cycle after each beat.
// 5. req0 drops after beat 2 of 8 -> gnt0 falls the same cycle, no beat counted, ptr=1; a pending req3 is granted after one IDLE cycle.
// 6. ena=0 mid-burst -> gnt=0 and oe=00 immediately, IDLE next edge; with ena=1 again and req=0001, dir0=1, a TURN cycle precedes the grant.

Source files
------------

// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pad-bus arbiter.
// Holds the FSM state encoding, pad-enable values and a counter-width helper.
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam logic [7:0] OE_DRIVE  = 8'hFF;
  localparam logic [7:0] OE_SAMPLE = 8'h00;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uio_rr_picker.sv
// Combinational round-robin pick: first set request scanning ptr, ptr+1, ... mod N_REQ.
// Reports the winning index and whether any request is set.
module uio_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the far end so the request closest to ptr overwrites last.
  always_comb begin
    idx = '0;
    any = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        idx = IDX_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit bidirectional uio pad bus between N_REQ requesters,
// with bounded bursts and a turnaround gap of uio_oe=00 whenever the bus direction flips.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 8,
  parameter int TURNAROUND = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   dir,
  input  logic [N_REQ-1:0]   last,
  input  logic [N_REQ*8-1:0] wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [7:0]         rdata,
  output logic               rvalid,
  output logic               busy,
  input  logic [7:0]         uio_in,
  output logic [7:0]         uio_out,
  output logic [7:0]         uio_oe
);

  localparam int IDX_W  = cnt_w(N_REQ);
  localparam int BCNT_W = cnt_w(MAX_BURST);
  localparam int TCNT_W = cnt_w(TURNAROUND + 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    w_q, w_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                dir_q, dir_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                beat;
  logic                final_beat;
  logic [IDX_W-1:0]    ptr_after_w;
  logic [7:0]          wsel;

  uio_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    gnt = '0;
    if (ena && state_q == GRANT) begin
      gnt[w_q] = req[w_q];
    end
  end

  assign beat        = gnt[w_q];
  assign final_beat  = last[w_q] || (bcnt_q == BCNT_W'(MAX_BURST - 1));
  assign ptr_after_w = (w_q == IDX_W'(N_REQ - 1)) ? '0 : w_q + 1'b1;
  assign wsel        = wdata[8*w_q +: 8];

  // Pads stay released through the turnaround and whenever the block is deselected.
  assign uio_oe  = (ena && state_q != TURN && dir_q) ? OE_DRIVE : OE_SAMPLE;
  assign uio_out = (beat && dir_q) ? wsel : 8'h00;
  assign busy    = (state_q != IDLE);
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    ptr_d    = ptr_q;
    dir_d    = dir_q;
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (!ena) begin
      state_d = IDLE;
      dir_d   = 1'b0;
      tcnt_d  = '0;
      bcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            w_d = pick_idx;
            if (dir[pick_idx] == dir_q) begin
              state_d = GRANT;
            end else begin
              state_d = TURN;
              tcnt_d  = TCNT_W'(TURNAROUND);
            end
          end
        end
        TURN: begin
          // TURN is only entered on a direction change, so the exit simply flips dir_q.
          tcnt_d = tcnt_q - 1'b1;
          if (tcnt_q == TCNT_W'(1)) begin
            state_d = GRANT;
            dir_d   = ~dir_q;
          end
        end
        GRANT: begin
          if (!req[w_q]) begin
            state_d = IDLE;
            ptr_d   = ptr_after_w;
            bcnt_d  = '0;
          end else begin
            if (!dir_q) begin
              rdata_d  = uio_in;
              rvalid_d = 1'b1;
            end
            if (final_beat) begin
              state_d = IDLE;
              ptr_d   = ptr_after_w;
              bcnt_d  = '0;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      w_q      <= '0;
      ptr_q    <= '0;
      dir_q    <= 1'b0;
      tcnt_q   <= '0;
      bcnt_q   <= '0;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      ptr_q    <= ptr_d;
      dir_q    <= dir_d;
      tcnt_q   <= tcnt_d;
      bcnt_q   <= bcnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model of the arbitration rules.
module tb_uio_bus_arbiter;

  localparam int N  = 4;
  localparam int MB = 8;
  localparam int TA = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           ena;
  logic [N-1:0]   req;
  logic [N-1:0]   dir;
  logic [N-1:0]   last;
  logic [N*8-1:0] wdata;
  logic [7:0]     uio_in;
  logic [N-1:0]   gnt;
  logic [7:0]     rdata;
  logic           rvalid;
  logic           busy;
  logic [7:0]     uio_out;
  logic [7:0]     uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uio_bus_arbiter #(
    .N_REQ      (N),
    .MAX_BURST  (MB),
    .TURNAROUND (TA)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .req     (req),
    .dir     (dir),
    .last    (last),
    .wdata   (wdata),
    .gnt     (gnt),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .busy    (busy),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Reference model: mode 0 = bus parked, 1 = switching direction, 2 = serving an owner.
  int         m_mode  = 0;
  int         m_owner = 0;
  int         m_start = 0;
  int         m_gap   = 0;
  int         m_beats = 0;
  bit         m_drive = 1'b0;
  bit         m_rvalid = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  function automatic logic [29:0] model_expect();
    logic [N-1:0] g;
    logic [7:0]   oe;
    logic [7:0]   out;
    logic         bsy;
    g = '0;
    if (ena && m_mode == 2 && req[m_owner]) g[m_owner] = 1'b1;
    oe  = (ena && m_mode != 1 && m_drive) ? 8'hFF : 8'h00;
    out = ((g != 0) && m_drive) ? wdata[m_owner*8 +: 8] : 8'h00;
    bsy = (m_mode != 0);
    return {g, oe, out, bsy, m_rvalid, m_rdata};
  endfunction

  task automatic model_step();
    bit done;
    if (rst) begin
      m_mode = 0; m_owner = 0; m_start = 0; m_gap = 0; m_beats = 0;
      m_drive = 1'b0; m_rvalid = 1'b0; m_rdata = 8'h00;
      return;
    end
    if (!ena) begin
      m_mode = 0; m_drive = 1'b0; m_beats = 0; m_rvalid = 1'b0;
      return;
    end
    m_rvalid = 1'b0;
    done = 1'b0;
    case (m_mode)
      0: begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_start + k) % N;
          if (req[i]) begin
            m_owner = i;
            m_mode  = (dir[i] == m_drive) ? 2 : 1;
            m_gap   = TA;
            break;
          end
        end
      end
      1: begin
        m_gap = m_gap - 1;
        if (m_gap == 0) begin
          m_mode  = 2;
          m_drive = !m_drive;
        end
      end
      default: begin
        if (!req[m_owner]) begin
          done = 1'b1;
        end else begin
          if (!m_drive) begin
            m_rdata  = uio_in;
            m_rvalid = 1'b1;
          end
          m_beats = m_beats + 1;
          if (last[m_owner] || m_beats == MB) done = 1'b1;
        end
      end
    endcase
    if (done) begin
      m_mode  = 0;
      m_start = (m_owner + 1) % N;
      m_beats = 0;
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b1; ena = 1'b1; req = '0; dir = '0; last = '0;
    #1;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; dir = '1; last = '0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if ({gnt, uio_oe, uio_out, rvalid, busy} !== 22'd0)
        begin n_fail++; $display("FAIL reset cyc %0d: got gnt=%b oe=%h out=%h rvalid=%b busy=%b, required all zero", c, gnt, uio_oe, uio_out, rvalid, busy); end
      advance();
    end
    rst = 1'b0; req = '0; dir = '0;
  endtask

  task automatic test_drive_burst();
    logic [29:0] ev;
    int beats = 0, first = -1, turn = 0, good = 0;
    reset_pulse();
    dir = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      wdata = $urandom; wdata[7:0] = 8'hA5;
      req[0] = (beats < 3);
      last[0] = (beats == 2);
      #1;
      ev = model_expect();
      n_checks++;
      if ({gnt, uio_oe, uio_out, busy, rvalid, rdata} !== ev)
        begin n_fail++; $display("FAIL drive_burst cyc %0d: got %h required %h", c, {gnt, uio_oe, uio_out, busy, rvalid, rdata}, ev); end
      if (first < 0 && busy && uio_oe == 8'h00) turn++;
      if (gnt[0]) begin
        if (first < 0) first = c;
        beats++;
        if (uio_out == 8'hA5 && uio_oe == 8'hFF) good++;
      end
      advance();
    end
    n_checks++;
    if (beats !== 3) begin n_fail++; $display("FAIL drive_burst_beats: got %0d required 3", beats); end
    n_checks++;
    if (turn !== 1) begin n_fail++; $display("FAIL drive_burst_turn: got %0d required 1", turn); end
    n_checks++;
    if (first !== 2) begin n_fail++; $display("FAIL drive_burst_latency: got cyc %0d required 2", first); end
    n_checks++;
    if (good !== 3) begin n_fail++; $display("FAIL drive_burst_data: got %0d A5 beats required 3", good); end
    #1;
    n_checks++;
    if (uio_oe !== 8'hFF || busy !== 1'b0) begin n_fail++; $display("FAIL drive_burst_park: got oe=%h busy=%b required FF 0", uio_oe, busy); end
  endtask

  task automatic test_back_to_back();
    logic [29:0] ev;
    logic [N-1:0] prev = '0;
    int own [6];
    int len [6];
    int nb = 0;
    for (int b = 0; b < 6; b++) begin own[b] = -1; len[b] = 0; end
    reset_pulse();
    req = '1; dir = '1; last = '0;
    for (int c = 0; c < 52; c++) begin
      wdata = $urandom; uio_in = 8'($urandom);
      #1;
      ev = model_expect();
      n_checks++;
      if ({gnt, uio_oe, uio_out, busy, rvalid, rdata} !== ev)
        begin n_fail++; $display("FAIL back_to_back cyc %0d: got %h required %h", c, {gnt, uio_oe, uio_out, busy, rvalid, rdata}, ev); end
      if (gnt != 0) begin
        if (gnt != prev) begin
          if (nb < 6) for (int i = 0; i < N; i++) if (gnt[i]) own[nb] = i;
          nb++;
        end
        if (nb >= 1 && nb <= 6) len[nb-1]++;
      end
      prev = gnt;
      advance();
    end
    for (int b = 0; b < 5; b++) begin
      n_checks++;
      if (own[b] !== b % N) begin n_fail++; $display("FAIL rr_order burst %0d: got owner %0d required %0d", b, own[b], b % N); end
      n_checks++;
      if (len[b] !== MB) begin n_fail++; $display("FAIL rr_length burst %0d: got %0d required %0d", b, len[b], MB); end
    end
    req = '0;
  endtask

  task automatic test_turnaround_sample();
    logic [29:0] ev;
    int c1 = 0, c2 = 0, rv = 0, t0 = 0;
    reset_pulse();
    dir = 4'b0010; uio_in = 8'h3C;
    for (int c = 0; c < 16; c++) begin
      wdata = $urandom;
      req = '0; last = '0;
      req[1] = (c1 < 2); last[1] = (c1 == 1);
      req[2] = (c2 < 3); last[2] = (c2 == 2);
      #1;
      ev = model_expect();
      n_checks++;
      if ({gnt, uio_oe, uio_out, busy, rvalid, rdata} !== ev)
        begin n_fail++; $display("FAIL turnaround cyc %0d: got %h required %h", c, {gnt, uio_oe, uio_out, busy, rvalid, rdata}, ev); end
      if (rvalid && rdata == 8'h3C) rv++;
      if (c1 == 2 && c2 == 0 && busy && gnt == 0 && uio_oe == 8'h00) t0++;
      if (gnt[1]) c1++;
      if (gnt[2]) c2++;
      advance();
    end
    n_checks++;
    if (t0 !== 1) begin n_fail++; $display("FAIL turnaround_gap: got %0d required 1", t0); end
    n_checks++;
    if (rv !== 3) begin n_fail++; $display("FAIL sample_rvalid: got %0d required 3", rv); end
    n_checks++;
    if (c2 !== 3) begin n_fail++; $display("FAIL sample_beats: got %0d required 3", c2); end
    req = '0; last = '0;
  endtask

  task automatic test_req_drop();
    logic [29:0] ev;
    int c0 = 0, drop = -1, g3 = -1;
    reset_pulse();
    dir = '0;
    for (int c = 0; c < 14; c++) begin
      uio_in = 8'($urandom); wdata = $urandom;
      req = '0; last = 4'b1000;
      req[0] = (c0 < 2);
      req[3] = (g3 < 0);
      #1;
      ev = model_expect();
      n_checks++;
      if ({gnt, uio_oe, uio_out, busy, rvalid, rdata} !== ev)
        begin n_fail++; $display("FAIL req_drop cyc %0d: got %h required %h", c, {gnt, uio_oe, uio_out, busy, rvalid, rdata}, ev); end
      if (c0 == 2 && drop < 0) begin
        drop = c;
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b1) begin n_fail++; $display("FAIL req_drop_release: got gnt=%b busy=%b required 0000 1", gnt, busy); end
      end
      if (gnt[0]) c0++;
      if (gnt[3] && g3 < 0) g3 = c;
      advance();
    end
    n_checks++;
    if (g3 !== drop + 2) begin n_fail++; $display("FAIL req_drop_next: got gnt3 at %0d required %0d", g3, drop + 2); end
    req = '0; last = '0;
  endtask

  task automatic test_ena_low();
    logic [29:0] ev;
    reset_pulse();
    req = 4'b0001; dir = 4'b0001; last = '0;
    for (int c = 0; c < 14; c++) begin
      wdata = $urandom;
      ena = !(c == 4 || c == 5);
      #1;
      ev = model_expect();
      n_checks++;
      if ({gnt, uio_oe, uio_out, busy, rvalid, rdata} !== ev)
        begin n_fail++; $display("FAIL ena_low cyc %0d: got %h required %h", c, {gnt, uio_oe, uio_out, busy, rvalid, rdata}, ev); end
      if (c == 4) begin
        n_checks++;
        if (gnt !== 4'b0000 || uio_oe !== 8'h00) begin n_fail++; $display("FAIL ena_low_immediate: got gnt=%b oe=%h required 0000 00", gnt, uio_oe); end
      end
      if (c == 5) begin
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ena_low_idle: got busy=%b required 0", busy); end
      end
      if (c == 7) begin
        n_checks++;
        if (busy !== 1'b1 || gnt !== 4'b0000 || uio_oe !== 8'h00) begin n_fail++; $display("FAIL ena_turn: got busy=%b gnt=%b oe=%h required 1 0000 00", busy, gnt, uio_oe); end
      end
      if (c == 8) begin
        n_checks++;
        if (gnt !== 4'b0001 || uio_oe !== 8'hFF) begin n_fail++; $display("FAIL ena_regrant: got gnt=%b oe=%h required 0001 FF", gnt, uio_oe); end
      end
      advance();
    end
    ena = 1'b1; req = '0;
  endtask

  task automatic test_random();
    logic [29:0] ev;
    reset_pulse();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      ena = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin req[i] = 1'b1; dir[i] = 1'($urandom_range(0, 1)); end
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
        if ($urandom_range(0, 9) == 0) dir[i] = ~dir[i];
        last[i] = ($urandom_range(0, 7) == 0);
      end
      wdata = $urandom; uio_in = 8'($urandom);
      #1;
      ev = model_expect();
      n_checks++;
      if ({gnt, uio_oe, uio_out, busy, rvalid, rdata} !== ev)
        begin n_fail++; $display("FAIL random cyc %0d: got %h required %h", c, {gnt, uio_oe, uio_out, busy, rvalid, rdata}, ev); end
      advance();
    end
    rst = 1'b0; ena = 1'b1; req = '0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; req = '0; dir = '0; last = '0; wdata = '0; uio_in = 8'h00;
    model_step();
    @(negedge clk);
    test_reset();
    test_drive_burst();
    test_back_to_back();
    test_turnaround_sample();
    test_req_drop();
    test_ena_low();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
